// File: rtl/wrap_event_scheduler.sv
// Wrap event scheduler: waiters post a one-cycle request and are released on a later
// wrap of a free-running counter, either one at a time (round-robin) or all together.
module wrap_event_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             bcast,
  input  logic [N_REQ-1:0] req,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_pulse,
  output logic [N_REQ-1:0] done,
  output logic [TS_W-1:0]  done_ts,
  output logic [N_REQ-1:0] pending,
  output logic             req_drop
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0] N_LIM = (PTR_W + 1)'(N_REQ);

  logic [TS_W-1:0]    time_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [N_REQ-1:0]   pending_next;
  logic               drop_next;
  logic               wrap_edge;
  logic [N_REQ-1:0]   rel;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               found;
  logic [PTR_W-1:0]   offset;
  logic [PTR_W:0]     sum;
  logic [PTR_W:0]     grant_wide;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W:0]     succ;

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= '0;
      cnt        <= '0;
      wrap_pulse <= 1'b0;
      done       <= '0;
      done_ts    <= '0;
      pending    <= '0;
      req_drop   <= 1'b0;
      ptr        <= '0;
    end else begin
      time_q     <= time_q + TS_W'(1);
      cnt        <= cnt_en ? cnt + CNT_W'(1) : cnt;
      wrap_pulse <= wrap_edge;
      done       <= rel;
      if (|rel) done_ts <= time_q + TS_W'(1);
      pending    <= pending_next;
      req_drop   <= drop_next;
      ptr        <= ptr_next;
    end
  end

  // Rotate pending so the pointer sits at bit 0; the lowest set bit is the grant offset.
  always_comb begin
    wrap_edge = cnt_en && (cnt == '1);
    dbl       = {pending, pending} >> ptr;
    rot       = dbl[N_REQ-1:0];
    found     = 1'b0;
    offset    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found  = 1'b1;
        offset = PTR_W'(k);
      end
    end
    sum        = {1'b0, ptr} + {1'b0, offset};
    grant_wide = (sum >= N_LIM) ? sum - N_LIM : sum;
    grant      = grant_wide[PTR_W-1:0];
    succ       = {1'b0, grant} + (PTR_W + 1)'(1);
  end

  // Eligibility uses the registered pending bits, so a request landing on the wrap edge waits a full wrap.
  always_comb begin
    rel      = '0;
    ptr_next = ptr;
    if (wrap_edge) begin
      if (bcast) begin
        rel = pending;
      end else if (found) begin
        rel[grant] = 1'b1;
        ptr_next   = (succ == N_LIM) ? '0 : succ[PTR_W-1:0];
      end
    end
    pending_next = (pending & ~rel) | (req & ~pending);
    drop_next    = req_drop | (|(req & pending));
  end

endmodule

// File: tb/tb_wrap_event_scheduler.sv
// Self-checking bench for wrap_event_scheduler: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the scheduling rules.
module tb_wrap_event_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int TS_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cnt_en = 1'b0;
  logic             bcast = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [CNT_W-1:0] cnt;
  logic             wrap_pulse;
  logic [N_REQ-1:0] done;
  logic [TS_W-1:0]  done_ts;
  logic [N_REQ-1:0] pending;
  logic             req_drop;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int               m_time, m_cnt, m_ptr, m_ts;
  logic [N_REQ-1:0] m_pend, m_done;
  logic             m_wrap, m_drop;

  wrap_event_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .bcast(bcast), .req(req),
    .cnt(cnt), .wrap_pulse(wrap_pulse), .done(done), .done_ts(done_ts),
    .pending(pending), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Scheduling rules applied to one clock edge with the inputs sampled at that edge.
  task automatic modelUpdate(input logic r, input logic en, input logic bc, input logic [N_REQ-1:0] rq);
    logic [N_REQ-1:0] relv;
    logic             wrap;
    if (r) begin
      m_time = 0; m_cnt = 0; m_ptr = 0; m_ts = 0;
      m_pend = '0; m_done = '0; m_wrap = 1'b0; m_drop = 1'b0;
      return;
    end
    wrap = en && (m_cnt == (1 << CNT_W) - 1);
    relv = '0;
    if (wrap) begin
      if (bc) begin
        relv = m_pend;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          int i = (m_ptr + k) % N_REQ;
          if (m_pend[i]) begin
            relv[i] = 1'b1;
            m_ptr = (i + 1) % N_REQ;
            break;
          end
        end
      end
    end
    if ((rq & m_pend) != '0) m_drop = 1'b1;
    m_pend = (m_pend & ~relv) | (rq & ~m_pend);
    m_time = (m_time + 1) % (1 << TS_W);
    if (relv != '0) m_ts = m_time;
    m_done = relv;
    m_wrap = wrap;
    m_cnt  = en ? (m_cnt + 1) % (1 << CNT_W) : m_cnt;
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic bc, input logic [N_REQ-1:0] rq);
    rst = r; cnt_en = en; bcast = bc; req = rq;
    @(posedge clk);
    modelUpdate(r, en, bc, rq);
    #1;
    if (r) cyc = 0;
    else cyc++;
    checkOutput("cnt", 32'(cnt), 32'(m_cnt));
    checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("done_ts", 32'(done_ts), 32'(m_ts));
    checkOutput("pending", 32'(pending), 32'(m_pend));
    checkOutput("req_drop", 32'(req_drop), 32'(m_drop));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_cnt", 32'(cnt), 32'd0);
    checkOutput("rst_done_ts", 32'(done_ts), 32'd0);
  endtask

  initial begin
    logic [N_REQ-1:0] rq;

    $display("[TB] scenario 1: round-robin release of two waiters");
    doReset();
    for (int c = 0; c < 34; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 2) ? 4'b0010 : (c == 3) ? 4'b0001 : 4'b0000);
      if (cyc == 15) checkOutput("s1_wrap15", 32'(wrap_pulse), 32'd0);
      if (cyc == 16) begin
        checkOutput("s1_wrap16", 32'(wrap_pulse), 32'd1);
        checkOutput("s1_cnt16", 32'(cnt), 32'd0);
        checkOutput("s1_done16", 32'(done), 32'b0001);
        checkOutput("s1_ts16", 32'(done_ts), 32'd16);
      end
      if (cyc == 32) begin
        checkOutput("s1_done32", 32'(done), 32'b0010);
        checkOutput("s1_ts32", 32'(done_ts), 32'd32);
      end
      if (cyc == 33) checkOutput("s1_pend33", 32'(pending), 32'd0);
    end

    $display("[TB] scenario 2: broadcast release");
    doReset();
    for (int c = 0; c < 34; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, (c == 2) ? 4'b0010 : (c == 3) ? 4'b0001 : 4'b0000);
      if (cyc == 16) begin
        checkOutput("s2_done16", 32'(done), 32'b0011);
        checkOutput("s2_ts16", 32'(done_ts), 32'd16);
      end
      if (cyc == 32) checkOutput("s2_done32", 32'(done), 32'd0);
    end

    $display("[TB] scenario 3: request on the wrap edge");
    doReset();
    for (int c = 0; c < 33; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 15) ? 4'b0100 : 4'b0000);
      if (cyc == 16) checkOutput("s3_done16", 32'(done), 32'd0);
      if (cyc == 32) checkOutput("s3_done32", 32'(done), 32'b0100);
    end

    $display("[TB] scenario 4: all four requesters, round-robin order");
    doReset();
    for (int c = 0; c < 82; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 0) ? 4'b1111 : (c == 20) ? 4'b0001 : 4'b0000);
      if (cyc == 16) checkOutput("s4_done16", 32'(done), 32'b0001);
      if (cyc == 32) checkOutput("s4_done32", 32'(done), 32'b0010);
      if (cyc == 48) checkOutput("s4_done48", 32'(done), 32'b0100);
      if (cyc == 64) checkOutput("s4_done64", 32'(done), 32'b1000);
      if (cyc == 80) checkOutput("s4_done80", 32'(done), 32'b0001);
    end

    $display("[TB] scenario 5: counter stalled for ten cycles");
    doReset();
    for (int c = 0; c < 28; c++) begin
      applyStimulus(1'b0, !(c >= 5 && c <= 14), 1'b0, (c == 1) ? 4'b1000 : 4'b0000);
      if (cyc == 16) checkOutput("s5_wrap16", 32'(wrap_pulse), 32'd0);
      if (cyc == 26) begin
        checkOutput("s5_wrap26", 32'(wrap_pulse), 32'd1);
        checkOutput("s5_done26", 32'(done), 32'b1000);
        checkOutput("s5_ts26", 32'(done_ts), 32'd26);
      end
    end

    $display("[TB] scenario 6: duplicate request and mid-run reset");
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 2 || c == 4) ? 4'b0010 : 4'b0000);
      if (cyc == 4) checkOutput("s6_drop4", 32'(req_drop), 32'd0);
      if (cyc == 5) checkOutput("s6_drop5", 32'(req_drop), 32'd1);
    end
    doReset();
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b0, (c == 2) ? 4'b0010 : 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("s6_pend_rst", 32'(pending), 32'd0);
    for (int c = 0; c < 34; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 3) ? 4'b0001 : 4'b0000);
      if (cyc == 16) begin
        checkOutput("s6_done16", 32'(done), 32'b0001);
        checkOutput("s6_ts16", 32'(done_ts), 32'd16);
      end
      if (cyc == 32) checkOutput("s6_done32", 32'(done), 32'd0);
    end

    $display("[TB] random traffic");
    doReset();
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < N_REQ; b++) rq[b] = ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85,
                    $urandom_range(0, 3) == 0, rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
